guess_round_ctrl: RTL and testbench



---
 rtl/guess_game_pkg.sv | 17 +
 rtl/guess_round_ctrl_entry_buf.sv | 32 +++
 rtl/guess_round_ctrl.sv | 100 ++++++++++
 tb/tb_guess_round_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared types and constants for the hex guess round controller.
// Imported by the round FSM and the nibble entry buffer.
package guess_game_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] WIN_COUNT = 4'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    SCORE = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_e;

endpackage

// File: rtl/guess_round_ctrl_entry_buf.sv
// Shift-in buffer collecting hex digits MS-first, with a digit counter.
// flush and clear both win over enter.
module nibble_entry_buf
  import guess_game_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             clear,
  input  logic                             enter,
  input  logic [DIGIT_W-1:0]               digit,
  output logic [NUM_DIGITS*DIGIT_W-1:0]    entry_digits,
  output logic [2:0]                       digit_count,
  output logic                             full
);

  assign full = (digit_count == 3'(NUM_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_digits <= '0;
      digit_count  <= '0;
    end else if (flush || clear) begin
      entry_digits <= '0;
      digit_count  <= '0;
    end else if (enter && !full) begin
      entry_digits <= {entry_digits[(NUM_DIGITS-1)*DIGIT_W-1:0], digit};
      digit_count  <= digit_count + 3'd1;
    end
  end

endmodule

// File: rtl/guess_round_ctrl.sv
// Round FSM in front of the hex guess scorer: latches the secret,
// commits 4-digit guesses, samples the score and tracks attempts.
module guess_round_ctrl
  import guess_game_pkg::*;
#(
  parameter int MAX_TRIES = 8,
  parameter int TRY_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      secret_in,
  input  logic [3:0]       digit_in,
  input  logic             digit_enter,
  input  logic             digit_clear,
  input  logic [3:0]       correct_digits,
  input  logic [3:0]       wrong_place_digits,
  output logic [15:0]      secret_number,
  output logic [15:0]      user_guess,
  output logic [15:0]      entry_digits,
  output logic [2:0]       digit_count,
  output logic             guess_valid,
  output logic [3:0]       last_correct,
  output logic [3:0]       last_wrong,
  output logic             score_valid,
  output logic [TRY_W-1:0] tries_used,
  output logic             playing,
  output logic             won,
  output logic             lost
);

  state_e state;
  logic   in_entry;
  logic   buf_full;
  logic   commit;
  logic   last_try;

  assign in_entry = (state == ENTRY);
  assign commit = in_entry && digit_enter && !digit_clear &&
                  (digit_count == 3'(NUM_DIGITS - 1));
  assign last_try = ((tries_used + 1'b1) == TRY_W'(MAX_TRIES));

  assign guess_valid = (state == SCORE);
  assign playing = in_entry || (state == SCORE);
  assign won = (state == WON);
  assign lost = (state == LOST);

  nibble_entry_buf u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (start || (state == SCORE)),
    .clear        (in_entry && digit_clear),
    .enter        (in_entry && digit_enter),
    .digit        (digit_in),
    .entry_digits (entry_digits),
    .digit_count  (digit_count),
    .full         (buf_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      secret_number <= '0;
      user_guess    <= '0;
      last_correct  <= '0;
      last_wrong    <= '0;
      score_valid   <= 1'b0;
      tries_used    <= '0;
    end else if (start) begin
      state         <= ENTRY;
      secret_number <= secret_in;
      user_guess    <= '0;
      last_correct  <= '0;
      last_wrong    <= '0;
      score_valid   <= 1'b0;
      tries_used    <= '0;
    end else begin
      score_valid <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (commit && !buf_full) begin
            user_guess <= {entry_digits[11:0], digit_in};
            state      <= SCORE;
          end
        end
        SCORE: begin
          last_correct <= correct_digits;
          last_wrong   <= wrong_place_digits;
          score_valid  <= 1'b1;
          tries_used   <= tries_used + 1'b1;
          if (correct_digits == WIN_COUNT) state <= WON;
          else if (last_try) state <= LOST;
          else state <= ENTRY;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with MAX_TRIES=2 and a
// score scoreboard queue checked on each score_valid pulse.
module tb_guess_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] secret_in = '0;
  logic [3:0]  digit_in = '0;
  logic        digit_enter = 1'b0;
  logic        digit_clear = 1'b0;
  logic [3:0]  correct_digits = '0;
  logic [3:0]  wrong_place_digits = '0;
  logic [15:0] secret_number, user_guess, entry_digits;
  logic [2:0]  digit_count;
  logic        guess_valid, score_valid, playing, won, lost;
  logic [3:0]  last_correct, last_wrong, tries_used;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb_q[$];

  guess_round_ctrl #(.MAX_TRIES(2), .TRY_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .secret_in(secret_in),
    .digit_in(digit_in), .digit_enter(digit_enter),
    .digit_clear(digit_clear), .correct_digits(correct_digits),
    .wrong_place_digits(wrong_place_digits),
    .secret_number(secret_number), .user_guess(user_guess),
    .entry_digits(entry_digits), .digit_count(digit_count),
    .guess_valid(guess_valid), .last_correct(last_correct),
    .last_wrong(last_wrong), .score_valid(score_valid),
    .tries_used(tries_used), .playing(playing), .won(won), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [3:0] d);
    digit_in = d;
    digit_enter = 1'b1;
    step();
    digit_enter = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] g);
    enter(g[15:12]);
    enter(g[11:8]);
    enter(g[7:4]);
    enter(g[3:0]);
  endtask

  task automatic begin_round(input logic [15:0] s);
    secret_in = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_score();
    logic [11:0] e;
    bit seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (score_valid) seen = 1;
    end
    tests++;
    assert (seen && sb_q.size() > 0) else begin
      fails++;
      $error("FAIL score_timeout observed=%0d expected=1", seen);
    end
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("last_correct", 32'(last_correct), 32'(e[11:8]));
      chk("last_wrong", 32'(last_wrong), 32'(e[7:4]));
      chk("tries_used", 32'(tries_used), 32'(e[3:0]));
    end
  endtask

  initial begin
    #12;
    chk("rst_secret", 32'(secret_number), 0);
    chk("rst_guess", 32'(user_guess), 0);
    chk("rst_flags", 32'({playing, won, lost, guess_valid, score_valid}), 0);
    rst_n = 1'b1;
    step();
    enter(4'h7);
    chk("idle_enter_count", 32'(digit_count), 0);
    chk("idle_playing", 32'(playing), 0);

    begin_round(16'h4AC1);
    chk("start_secret", 32'(secret_number), 32'h4AC1);
    chk("start_playing", 32'(playing), 1);
    correct_digits = 4'd0;
    wrong_place_digits = 4'd1;
    sb_q.push_back({4'd0, 4'd1, 4'd1});
    enter4(16'hB948);
    chk("g1_user_guess", 32'(user_guess), 32'hB948);
    chk("g1_guess_valid", 32'(guess_valid), 1);
    chk("g1_score_early", 32'(score_valid), 0);
    wait_score();
    chk("g1_count", 32'(digit_count), 0);
    chk("g1_back_entry", 32'({playing, guess_valid}), 32'b10);

    enter(4'h4);
    enter(4'hA);
    chk("partial_count", 32'(digit_count), 2);
    chk("partial_entry", 32'(entry_digits), 32'h004A);
    digit_clear = 1'b1;
    step();
    digit_clear = 1'b0;
    chk("clear_count", 32'(digit_count), 0);
    chk("clear_tries", 32'(tries_used), 1);
    correct_digits = 4'd4;
    wrong_place_digits = 4'd0;
    sb_q.push_back({4'd4, 4'd0, 4'd2});
    enter4(16'h4AC1);
    chk("g2_user_guess", 32'(user_guess), 32'h4AC1);
    wait_score();
    chk("final_try_win", 32'({won, lost, playing}), 32'b100);
    enter(4'h3);
    chk("won_ignore_enter", 32'(digit_count), 0);
    chk("won_hold_tries", 32'(tries_used), 2);

    begin_round(16'h1234);
    correct_digits = 4'd0;
    wrong_place_digits = 4'd4;
    sb_q.push_back({4'd0, 4'd4, 4'd1});
    enter4(16'h4321);
    wait_score();
    chk("l1_playing", 32'(playing), 1);
    sb_q.push_back({4'd0, 4'd4, 4'd2});
    enter4(16'h4321);
    wait_score();
    chk("lost_flags", 32'({won, lost, playing}), 32'b010);
    step();
    chk("lost_hold_tries", 32'(tries_used), 2);

    begin_round(16'h1234);
    chk("restart_tries", 32'(tries_used), 0);
    enter(4'h1);
    enter(4'h2);
    digit_in = 4'h9;
    digit_enter = 1'b1;
    digit_clear = 1'b1;
    step();
    digit_enter = 1'b0;
    digit_clear = 1'b0;
    chk("both_count", 32'(digit_count), 0);
    chk("both_entry", 32'(entry_digits), 0);
    correct_digits = 4'd1;
    wrong_place_digits = 4'd2;
    enter4(16'h5678);
    chk("abort_in_score", 32'(guess_valid), 1);
    begin_round(16'hFFFF);
    chk("abort_no_score", 32'(score_valid), 0);
    chk("abort_secret", 32'(secret_number), 32'hFFFF);
    chk("abort_tries", 32'(tries_used), 0);
    chk("abort_last", 32'({last_correct, last_wrong}), 0);
    step();
    chk("abort_no_score2", 32'(score_valid), 0);
    chk("abort_entry", 32'({playing, guess_valid}), 32'b10);

    enter(4'h1);
    enter(4'h2);
    enter(4'h3);
    chk("pre_rst_count", 32'(digit_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(digit_count), 0);
    chk("async_entry", 32'(entry_digits), 0);
    chk("async_secret", 32'(secret_number), 0);
    chk("async_flags", 32'({playing, won, lost}), 0);
    #10;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'({playing, won, lost}), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
